// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: register offsets, STATUS bit layout and TX FSM encoding.
// Imported by mmio_ctrl and mmio_tx_buf.
package mmio_pkg;

  localparam logic [7:0] OFS_STATUS  = 8'h00;
  localparam logic [7:0] OFS_RXDATA  = 8'h04;
  localparam logic [7:0] OFS_TXDATA  = 8'h08;
  localparam logic [7:0] OFS_CYCLE   = 8'h10;
  localparam logic [7:0] OFS_INSTRET = 8'h14;
  localparam logic [7:0] OFS_CNTRST  = 8'h18;

  localparam int ST_TX_IDLE  = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_DROP  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Field order mirrors the ST_* indices above (LSB last).
  typedef struct packed {
    logic [28:0] rsvd;
    logic        tx_drop;
    logic        rx_valid;
    logic        tx_idle;
  } status_t;

endpackage

// File: rtl/mmio_tx_buf.sv
// One-entry UART TX buffer: a load in IDLE captures the byte and presents it from the next cycle.
// Holds tx_valid/tx_data until tx_ready; loads arriving while SEND are refused and flagged on drop.
module mmio_tx_buf
  import mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       idle,
  output logic       drop
);

  tx_state_e  state;
  tx_state_e  state_nxt;
  logic [7:0] data_q;
  logic       capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 8'h00;
    end else if (capture) begin
      data_q <= load_byte;
    end
  end

  // A load in the handshake cycle still sees SEND and is refused.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        drop = load;
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_valid = (state == SEND);
  assign idle     = (state == IDLE);
  assign tx_data  = data_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0x8xxx_xxxx region: UART RX/TX sequencing, cycle/instret counters.
// Read data and hit flag are registered (1-cycle latency, same as dmem); TX backpressure is absorbed by a one-entry buffer.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [3:0] MMIO_TAG = 4'h8,
  parameter int         CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        hit_q,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic             tag_match;
  logic             rd_hit;
  logic             wr_hit;
  logic [7:0]       ofs;
  logic             tx_load;
  logic             cnt_clr;
  logic             status_rd;
  logic             tx_idle;
  logic             drop_pulse;
  logic             tx_drop;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  status_t          status;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign tag_match = (addr[31:28] == MMIO_TAG);
  assign ofs       = addr[7:0];
  assign rd_hit    = tag_match & re;
  assign wr_hit    = tag_match & (|wbe);

  assign rx_ready  = rd_hit & (ofs == OFS_RXDATA) & rx_valid;
  assign tx_load   = wr_hit & (ofs == OFS_TXDATA) & wbe[0];
  assign cnt_clr   = wr_hit & (ofs == OFS_CNTRST);
  assign status_rd = rd_hit & (ofs == OFS_STATUS);

  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  mmio_tx_buf u_tx_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_byte (wdata[7:0]),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .idle      (tx_idle),
    .drop      (drop_pulse)
  );

  always_comb begin
    status          = '0;
    status.tx_drop  = tx_drop;
    status.rx_valid = rx_valid;
    status.tx_idle  = tx_idle;
  end

  always_comb begin
    rd_mux = 32'h0;
    case (ofs)
      OFS_STATUS:  rd_mux = status;
      OFS_RXDATA:  rd_mux = rx_valid ? {24'h0, rx_data} : 32'h0;
      OFS_CYCLE:   rd_mux = 32'(cycle_cnt);
      OFS_INSTRET: rd_mux = 32'(instret_cnt);
      default:     rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'h0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= rd_hit;
      if (rd_hit) begin
        rdata <= rd_mux;
      end
    end
  end

  // A drop in the same cycle as a STATUS read wins over the read-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_drop <= 1'b0;
    end else begin
      tx_drop <= (tx_drop & ~status_rd) | drop_pulse;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + CNT_W'(1);
      instret_cnt <= instret_cnt + CNT_W'(inst_retire);
    end
  end

endmodule
